// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin search used by the adder arbiter.
// Pure declarations: no latency, no backpressure.
// rr_pick is combinational and is evaluated inside the arbiter's grant logic.
package adder_arb_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;

    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or above ptr, wrapping at n (n <= RR_MAX).
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0]   valid,
        input logic [RR_IDX_W-1:0] ptr,
        input int unsigned         n
    );
        rr_pick_t    r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            k = (32'(ptr) + i) % n;
            if (i < n && !r.found && valid[k[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Registered WIDTH-bit adder with carry-in/out, loaded only when en is high.
// Latency 1 cycle; outputs hold their last result while en is low.
// No backpressure: the caller decides when to load.
module n_bit_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            c <= 1'b0;
        end else if (en) begin
            {c, s} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one registered adder among NUM_REQ requesters.
// Latency: request handshake at edge N, response valid from edge N+2.
// One transaction in flight; response stall holds RESP and blocks all requests.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_s,
    output logic                     rsp_c
);

    arb_state_t            state, state_nxt;
    logic [ID_W-1:0]       rr_ptr, cur_id, grant;
    logic [RR_MAX-1:0]     valid_ext;
    logic [RR_IDX_W-1:0]   ptr_ext;
    rr_pick_t              pick;
    logic                  req_hs, rsp_hs;
    logic [WIDTH-1:0]      op_a, op_b, add_s;
    logic                  op_cin, add_c;
    logic                  unused_pick_idx;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = req_valid;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = rr_ptr;
        pick                   = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    end

    assign grant           = pick.idx[ID_W-1:0];
    assign unused_pick_idx = ^pick.idx;

    // Operands steered straight from the granted requester; the adder is the only storage.
    always_comb begin
        op_a   = req_a[grant*WIDTH +: WIDTH];
        op_b   = req_b[grant*WIDTH +: WIDTH];
        op_cin = req_cin[grant];
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        req_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (pick.found && !rst) begin
                    req_ready[grant] = 1'b1;
                    req_hs           = 1'b1;
                    state_nxt        = CALC;
                end
            end
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_hs    = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_id <= '0;
        end else begin
            state <= state_nxt;
            if (req_hs) cur_id <= grant;
            if (rsp_hs) rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
        end
    end

    n_bit_adder #(.WIDTH(WIDTH)) u_adder (
        .clk (clk),
        .rst (rst),
        .en  (req_hs),
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .s   (add_s),
        .c   (add_c)
    );

    assign rsp_id = cur_id;
    assign rsp_s  = rsp_valid ? add_s : '0;
    assign rsp_c  = rsp_valid ? add_c : 1'b0;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

- Round-robin arbiter and sequencer that shares one registered `n_bit_adder` among `NUM_REQ` requesters.
- Accepts one operand set at a time over a valid/ready handshake and drives the shared adder for one cycle.
- Returns the sum, carry and requester ID over a valid/ready response channel.
- Sits between client blocks and the single adder instance, so that no client drives the adder directly.

## Interface

Parameters:
- `WIDTH`, 8, operand/sum width passed to `n_bit_adder`
- `NUM_REQ`, 4, number of requesters (2..16)
- `ID_W`, `$clog2(NUM_REQ)`, requester ID width (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero
- `req_a`  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  NUM_REQ*WIDTH  operand B, same packing
- `req_cin`  in  NUM_REQ  carry-in per requester
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  ID_W  index of the requester that owns the result
- `rsp_s`  out  WIDTH  sum, (a+b+cin) mod 2^WIDTH
- `rsp_c`  out  1  carry-out of a+b+cin

## Operation

- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first i with `req_valid[i]`=1, searching from `rr_ptr` upward with wrap at NUM_REQ.
  - `req_ready[grant]`=1 combinationally; all other bits are 0.
  - On handshake, drive the adder with the granted a/b/cin and en=1, latch `grant` into `cur_id`, and go to CALC.
  - No valid: stay in IDLE, en=0, `req_ready`=0.
- CALC: en=0; the adder output registers now hold the result; go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_s`/`rsp_c` come from the adder outputs; `rsp_id`=`cur_id`.
  - Hold every response output stable until `rsp_ready`=1.
  - On `rsp_valid`&`rsp_ready`: set `rr_ptr` = (`cur_id`+1) mod NUM_REQ and go to IDLE.
- `req_ready` is 0 in CALC and RESP. Requesters keep `req_valid` and data stable until accepted.
- Deasserting `req_valid` before acceptance is legal; that requester is simply not granted.
- Only one transaction is in flight. The adder `en` is high only on the IDLE handshake cycle.
- Arithmetic: {`rsp_c`,`rsp_s`} = a + b + cin, computed at WIDTH+1 bits, unsigned.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 other transactions.

## Timing

- Reset (async assert, deasserted synchronously by the system):
  - state=IDLE, `rr_ptr`=0, `cur_id`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_c`=0.
  - Adder `rst` is tied to `rst`.
- Latency: request handshake at edge N, `rsp_valid`=1 from edge N+2.
- Minimum spacing between accepted requests is 3 cycles when `rsp_ready` is held high.
- Response stall: RESP holds indefinitely. New requests are not accepted, and `rsp_*` values do not change.
- Simultaneous valids: only the round-robin winner is readied; the others see `req_ready`=0.
- Pointer wrap: `cur_id`=NUM_REQ-1 gives `rr_ptr`=0 next.
- Reset mid-CALC or mid-RESP: the transaction is dropped with no response, and all outputs take their reset values immediately.
- Overflow: all-ones+all-ones+1 gives s=all-ones, c=1. No saturation is applied.

## Structure

- Package `adder_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t`
  - round-robin search function `rr_pick(valid, ptr)` returning the index and a found flag
- One sub-module: `n_bit_adder #(WIDTH)`, instantiated once.
  - Arbiter drives its `a`, `b`, `cin`, `en`, `rst`, `clk` and reads `s`, `c`.
- Operand muxing is combinational from the `grant` index; no operand registers exist outside the adder.

## Test plan

1. Reset mid-RESP:
   - Stimulus: requester 2 sends a=8'hFF, b=8'h01, cin=0; assert `rst` while in RESP.
   - Response: `rsp_valid`=0 at once, `rr_ptr`=0; a later request returns normally.
2. Single requester:
   - Stimulus: req 0 with a=8'h0F, b=8'h01, cin=1, `rsp_ready`=1.
   - Response: 2 cycles after the handshake, `rsp_s`=8'h11, `rsp_c`=0, `rsp_id`=0.
3. All four requesters valid continuously from reset:
   - Response: grant order 0,1,2,3,0; each response carries its own ID and correct sum.
4. Overflow:
   - Stimulus: req 3 with a=8'hFF, b=8'hFF, cin=1.
   - Response: `rsp_s`=8'hFF, `rsp_c`=1, `rsp_id`=3.
5. Response stall:
   - Stimulus: hold `rsp_ready`=0 for 10 cycles while req 1 stays valid.
   - Response: `rsp_*` stable, `req_ready`=0 throughout; req 1 is accepted on the cycle after the response handshake.
6. Random soak:
   - Stimulus: 500 transactions with random valids, operands and `rsp_ready`.
   - Response:
     - A scoreboard matches {c,s} = a+b+cin per ID.
     - No requester waits longer than NUM_REQ-1 grants.
     - No `rsp_*` value changes while stalled.
